// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default line settings.
package uart_pkg;

    localparam int DEF_CLK_FREQ  = 50_000_000;
    localparam int DEF_BAUD      = 115_200;
    localparam int DEF_OS        = 16;
    localparam int DEF_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Counter width for a modulus of v; never narrower than one bit so DIV=1 / OS=1 still elaborate.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock tick every DIV clocks.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int            W    = clog2_min1(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] div_q;

    // Count 0..DIV-1 and wrap; the tick is the terminal count.
    // NOTE: sequential state is updated with <= so every flop sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_q == LAST) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick_o = (div_q == LAST);

endmodule

// File: rtl/uart_rx_os16.sv
// Oversampling 8N1 UART receiver with 2-of-3 centre vote, valid and framing-error strobes.
module uart_rx_os16
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = DEF_CLK_FREQ,
    parameter int BAUD      = DEF_BAUD,
    parameter int OS        = DEF_OS,
    parameter int DATA_BITS = DEF_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 R_rdy,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OS);
    localparam int CNT_W = clog2_min1(OS);
    localparam int BIT_W = clog2_min1(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rx_s;
    logic [2:0]           vote_q;
    logic                 maj;

    uart_state_e          state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 rdy_q;
    logic                 err_q;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    // Two-flop synchroniser for the asynchronous line; resets to the idle (high) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], Rx};
        end
    end

    assign rx_s = sync_q[1];

    // Keep the last three oversamples for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_q <= 3'b111;
        end else if (tick) begin
            vote_q <= {vote_q[1:0], rx_s};
        end
    end

    assign maj = (vote_q[0] & vote_q[1]) | (vote_q[0] & vote_q[2]) | (vote_q[1] & vote_q[2]);

    // Frame FSM: start qualification, LSB-first data shift, stop check and strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: strobes default low every clock, so any branch that sets them yields a single-cycle pulse.
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_q <= ST_START;
                            cnt_q   <= '0;
                        end
                    end
                    ST_START: begin
                        if (cnt_q == CNT_MID) begin
                            if (!maj) begin
                                state_q <= ST_DATA;
                                cnt_q   <= '0;
                                bit_q   <= '0;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
                            cnt_q   <= '0;
                            if (bit_q == BIT_LAST) begin
                                state_q <= ST_STOP;
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            if (maj) begin
                                data_q <= shreg_q;
                                rdy_q  <= 1'b1;
                            end else begin
                                err_q  <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign data      = data_q;
    assign R_rdy     = rdy_q;
    assign frame_err = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: directed frames plus random 8N1 traffic against a frame-level model.
module tb_uart_rx_os16;

    localparam int BIT_CLK  = 432;  // 50 MHz / 115200 with 16 x 27-clock ticks
    localparam int TICK_CLK = 27;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Rx  = 1'b1;
    logic [7:0] data;
    logic       R_rdy;
    logic       frame_err;
    logic       busy;

    always #10 clk = ~clk;

    uart_rx_os16 dut (
        .clk       (clk),
        .rst       (rst),
        .Rx        (Rx),
        .data      (data),
        .R_rdy     (R_rdy),
        .frame_err (frame_err),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    // Observed strobes, collected on the falling edge.
    logic [7:0] rdy_q[$];
    int         err_n  = 0;
    int         both_n = 0;

    // Reference model: bytes that must be delivered, expected error count, byte data must hold.
    logic [7:0] exp_q[$];
    int         exp_err   = 0;
    logic [7:0] last_good = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (R_rdy)              rdy_q.push_back(data);
            if (frame_err)          err_n++;
            if (R_rdy && frame_err) both_n++;
        end
    end

    // Drive the line to v for n clocks; transitions land 1 ns after a rising edge.
    task automatic hold(input logic v, input int n);
        Rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame. glitch_bit in 0..7 inverts that data bit for one tick around its centre.
    // A bad stop bit is held low just past its centre, then the line returns to idle.
    task automatic send_frame(input logic [7:0] b, input bit bad_stop, input int glitch_bit);
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                hold(b[i], 203);
                hold(!b[i], TICK_CLK);
                hold(b[i], BIT_CLK - 203 - TICK_CLK);
            end else begin
                hold(b[i], BIT_CLK);
            end
        end
        if (bad_stop) begin
            hold(1'b0, 243);
            hold(1'b1, BIT_CLK - 243);
        end else begin
            hold(1'b1, BIT_CLK);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit bad_stop);
        if (bad_stop) begin
            exp_err++;
        end else begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    // Wait (bounded) for the modelled strobes, then compare counts, bytes and the held data.
    task automatic compare(input string tag);
        int n = 0;
        while ((rdy_q.size() < exp_q.size() || err_n < exp_err) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_nrdy"}, rdy_q.size(), exp_q.size());
        check({tag, "_nerr"}, err_n, exp_err);
        while (exp_q.size() > 0 && rdy_q.size() > 0) begin
            check({tag, "_byte"}, rdy_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        rdy_q.delete();
        check({tag, "_data"}, data, last_good);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        int         rgl;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_data", data, 8'h00);
        check("rst_rdy", R_rdy, 1'b0);
        check("rst_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        hold(1'b1, 2 * BIT_CLK);

        // Ideal 0xA5
        send_frame(8'hA5, 1'b0, -1);
        model_frame(8'hA5, 1'b0);
        compare("a5");
        hold(1'b1, BIT_CLK);
        check("a5_busy", busy, 1'b0);

        // Back-to-back 0x00, 0xFF
        send_frame(8'h00, 1'b0, -1);
        send_frame(8'hFF, 1'b0, -1);
        model_frame(8'h00, 1'b0);
        model_frame(8'hFF, 1'b0);
        compare("b2b");

        // 3-tick low glitch: false start, no strobes
        hold(1'b1, BIT_CLK);
        hold(1'b0, 3 * TICK_CLK);
        check("glitch_busy_hi", busy, 1'b1);
        hold(1'b1, 12 * TICK_CLK);
        check("glitch_busy_lo", busy, 1'b0);
        compare("glitch");

        // 0x3C with low stop bit: frame error, data keeps 0xFF
        hold(1'b1, BIT_CLK);
        send_frame(8'h3C, 1'b1, -1);
        model_frame(8'h3C, 1'b1);
        compare("ferr");

        // 0x55 with a one-tick inverted glitch at the centre of bit 3
        hold(1'b1, BIT_CLK);
        send_frame(8'h55, 1'b0, 3);
        model_frame(8'h55, 1'b0);
        compare("vote");

        // Reset mid bit 4 of 0x81, then 0x42
        hold(1'b1, BIT_CLK);
        hold(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) hold(((8'h81 >> i) & 8'h01) != 0, BIT_CLK);
        hold(1'b0, BIT_CLK / 2);
        rst = 1'b1;
        hold(1'b1, 1);
        check("mid_rst_data", data, 8'h00);
        check("mid_rst_rdy", R_rdy, 1'b0);
        check("mid_rst_err", frame_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        last_good = 8'h00;
        hold(1'b1, 2 * BIT_CLK);
        compare("abort");
        send_frame(8'h42, 1'b0, -1);
        model_frame(8'h42, 1'b0);
        compare("after_rst");

        // Random frames: random payload, stop errors, glitches and tick phase
        for (int k = 0; k < 6; k++) begin
            rb   = 8'($urandom);
            rbad = ($urandom_range(0, 3) == 0);
            rgl  = int'($urandom_range(0, 11));
            hold(1'b1, int'($urandom_range(0, 100)));
            send_frame(rb, rbad, rgl);
            model_frame(rb, rbad);
            compare($sformatf("rnd%0d", k));
        end

        hold(1'b1, BIT_CLK);
        check("final_busy", busy, 1'b0);
        check("strobe_exclusive", both_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
